simd_sign_restore: RTL and testbench

//  Output-side counterpart of the operand negation stage in the SIMD multiplier-divider.

---
 rtl/simd_sign_restore_if.sv | 26 ++
 rtl/simd_sign_restore.sv | 126 ++++++++++++
 tb/tb_simd_sign_restore.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/simd_sign_restore_if.sv
// Handshake bundle for the SIMD sign-restore stage: a valid/ready input beat carrying
// mode, operand signs and magnitude, and a valid/ready output beat carrying result and overflow.
interface simd_sign_restore_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic         mode;
    logic [1:0]   sign_a;
    logic [1:0]   sign_b;
    logic [W-1:0] mag;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res;
    logic [1:0]   ovf;

    modport master (
        output in_valid, mode, sign_a, sign_b, mag, out_ready,
        input  in_ready, out_valid, res, ovf
    );

    modport slave (
        input  in_valid, mode, sign_a, sign_b, mag, out_ready,
        output in_ready, out_valid, res, ovf
    );
endinterface

// File: rtl/simd_sign_restore.sv
// Reapplies the result sign (XOR of operand signs) to the unsigned core magnitude, for one
// W-bit lane or two W/2-bit lanes, in a 2-stage valid/ready pipeline with per-lane overflow.
module simd_sign_restore #(
    parameter int W   = 16,
    parameter bit SAT = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    simd_sign_restore_if.slave bus
);
    localparam int L = W / 2;

    // Returns {overflow, result} for a full-width lane.
    function automatic logic [W:0] lane_full(input logic [W-1:0] m, input logic neg);
        logic signed [W-1:0] r;
        logic                o;
        if (neg) begin
            r = $signed(~m + 1'b1);
            o = (m > {1'b1, {(W-1){1'b0}}});
            if (o && SAT) r = $signed({1'b1, {(W-1){1'b0}}});
        end else begin
            r = $signed(m);
            o = m[W-1];
            if (o && SAT) r = $signed({1'b0, {(W-1){1'b1}}});
        end
        return {o, r};
    endfunction

    function automatic logic [L:0] lane_half(input logic [L-1:0] m, input logic neg);
        logic signed [L-1:0] r;
        logic                o;
        if (neg) begin
            r = $signed(~m + 1'b1);
            o = (m > {1'b1, {(L-1){1'b0}}});
            if (o && SAT) r = $signed({1'b1, {(L-1){1'b0}}});
        end else begin
            r = $signed(m);
            o = m[L-1];
            if (o && SAT) r = $signed({1'b0, {(L-1){1'b1}}});
        end
        return {o, r};
    endfunction

    logic                rdy_q;
    logic                vld_p1_q, vld_p1_d;
    logic                mode_p1_q, mode_p1_d;
    logic [1:0]          neg_p1_q, neg_p1_d;
    logic [W-1:0]        mag_p1_q, mag_p1_d;
    logic                vld_p2_q, vld_p2_d;
    logic signed [W-1:0] res_p2_q, res_p2_d;
    logic [1:0]          ovf_p2_q, ovf_p2_d;
    logic                adv1, adv2, accept;
    logic [W:0]          full;
    logic [L:0]          hi, lo;

    // rdy_q holds in_ready low during reset and for the first cycle after release.
    assign adv2         = !vld_p2_q || bus.out_ready;
    assign adv1         = !vld_p1_q || adv2;
    assign bus.in_ready = adv1 && rdy_q;
    assign accept       = bus.in_valid && bus.in_ready;

    assign bus.out_valid = vld_p2_q;
    assign bus.res       = $unsigned(res_p2_q);
    assign bus.ovf       = ovf_p2_q;

    // Stage 1: capture beat and lane negate flags
    always_comb begin
        vld_p1_d  = vld_p1_q;
        mode_p1_d = mode_p1_q;
        neg_p1_d  = neg_p1_q;
        mag_p1_d  = mag_p1_q;
        if (adv1) begin
            vld_p1_d = accept;
            if (accept) begin
                mode_p1_d = bus.mode;
                mag_p1_d  = bus.mag;
                neg_p1_d  = {bus.mode & (bus.sign_a[1] ^ bus.sign_b[1]),
                             bus.sign_a[0] ^ bus.sign_b[0]};
            end
        end
    end

    // Stage 2: sign application, overflow detection and optional clamp
    always_comb begin
        vld_p2_d = vld_p2_q;
        res_p2_d = res_p2_q;
        ovf_p2_d = ovf_p2_q;
        full     = lane_full(mag_p1_q, neg_p1_q[0]);
        hi       = lane_half(mag_p1_q[W-1:L], neg_p1_q[1]);
        lo       = lane_half(mag_p1_q[L-1:0], neg_p1_q[0]);
        if (adv2) begin
            vld_p2_d = vld_p1_q;
            if (vld_p1_q) begin
                if (mode_p1_q) begin
                    res_p2_d = $signed({hi[L-1:0], lo[L-1:0]});
                    ovf_p2_d = {hi[L], lo[L]};
                end else begin
                    res_p2_d = $signed(full[W-1:0]);
                    ovf_p2_d = {1'b0, full[W]};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q     <= 1'b0;
            vld_p1_q  <= 1'b0;
            mode_p1_q <= 1'b0;
            neg_p1_q  <= '0;
            mag_p1_q  <= '0;
            vld_p2_q  <= 1'b0;
            res_p2_q  <= '0;
            ovf_p2_q  <= '0;
        end else begin
            rdy_q     <= 1'b1;
            vld_p1_q  <= vld_p1_d;
            mode_p1_q <= mode_p1_d;
            neg_p1_q  <= neg_p1_d;
            mag_p1_q  <= mag_p1_d;
            vld_p2_q  <= vld_p2_d;
            res_p2_q  <= res_p2_d;
            ovf_p2_q  <= ovf_p2_d;
        end
    end
endmodule

// File: tb/tb_simd_sign_restore.sv
// Directed bench for simd_sign_restore: a saturating and a wrapping instance fed identical beats.
module tb_simd_sign_restore;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    simd_sign_restore_if #(.W(16)) if_s ();
    simd_sign_restore_if #(.W(16)) if_w ();

    simd_sign_restore #(.W(16), .SAT(1'b1)) u_sat (.clk(clk), .rst_n(rst_n), .bus(if_s));
    simd_sign_restore #(.W(16), .SAT(1'b0)) u_wrap (.clk(clk), .rst_n(rst_n), .bus(if_w));

    assign if_w.in_valid  = if_s.in_valid;
    assign if_w.mode      = if_s.mode;
    assign if_w.sign_a    = if_s.sign_a;
    assign if_w.sign_b    = if_s.sign_b;
    assign if_w.mag       = if_s.mag;
    assign if_w.out_ready = if_s.out_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic m, input logic [1:0] sa,
                         input logic [1:0] sb, input logic [15:0] mg);
        if_s.in_valid = v;
        if_s.mode     = m;
        if_s.sign_a   = sa;
        if_s.sign_b   = sb;
        if_s.mag      = mg;
    endtask

    // One beat with out_ready high: present, then expect nothing after one edge and the
    // result after the second edge.
    task automatic run_beat(input string tag, input logic m, input logic [1:0] sa,
                            input logic [1:0] sb, input logic [15:0] mg,
                            input logic [15:0] er, input logic [1:0] eo,
                            input logic chk_w, input logic [15:0] erw, input logic [1:0] eow);
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'(if_s.in_ready), 32'd1);
        drive(1'b1, m, sa, sb, mg);
        @(negedge clk);
        drive(1'b0, 1'b0, 2'b00, 2'b00, 16'h0000);
        chk({tag, "_early_valid"}, 32'(if_s.out_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(if_s.out_valid), 32'd1);
        chk({tag, "_res"}, 32'(if_s.res), 32'(er));
        chk({tag, "_ovf"}, 32'(if_s.ovf), 32'(eo));
        if (chk_w) begin
            chk({tag, "_wrap_res"}, 32'(if_w.res), 32'(erw));
            chk({tag, "_wrap_ovf"}, 32'(if_w.ovf), 32'(eow));
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        if_s.out_ready = 1'b1;
        drive(1'b0, 1'b0, 2'b00, 2'b00, 16'h0000);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_out_valid", 32'(if_s.out_valid), 32'd0);
        chk("rst_res", 32'(if_s.res), 32'd0);
        chk("rst_ovf", 32'(if_s.ovf), 32'd0);
        chk("rst_in_ready", 32'(if_s.in_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #2 chk("rel_in_ready_low", 32'(if_s.in_ready), 32'd0);
        @(negedge clk);
        chk("rel_in_ready_high", 32'(if_s.in_ready), 32'd1);

        run_beat("T1_neg", 1'b0, 2'b01, 2'b00, 16'h0005, 16'hFFFB, 2'b00, 1'b1, 16'hFFFB, 2'b00);
        run_beat("T2_dual", 1'b1, 2'b10, 2'b00, 16'h0307, 16'hFD07, 2'b00, 1'b0, 16'h0, 2'b00);
        run_beat("T2_both", 1'b1, 2'b11, 2'b11, 16'h0307, 16'h0307, 2'b00, 1'b0, 16'h0, 2'b00);
        run_beat("T3_pos_ovf", 1'b0, 2'b00, 2'b00, 16'h8000, 16'h7FFF, 2'b01, 1'b1, 16'h8000, 2'b01);
        run_beat("T3_neg_min", 1'b0, 2'b01, 2'b00, 16'h8000, 16'h8000, 2'b00, 1'b1, 16'h8000, 2'b00);
        run_beat("T3_neg_ovf", 1'b0, 2'b00, 2'b01, 16'h8001, 16'h8000, 2'b01, 1'b1, 16'h7FFF, 2'b01);
        run_beat("T4_lane_ovf", 1'b1, 2'b10, 2'b00, 16'h8100, 16'h8000, 2'b10, 1'b1, 16'h7F00, 2'b10);
        run_beat("neg_zero", 1'b0, 2'b01, 2'b00, 16'h0000, 16'h0000, 2'b00, 1'b0, 16'h0, 2'b00);
        run_beat("m0_ign_hi", 1'b0, 2'b10, 2'b00, 16'h1234, 16'h1234, 2'b00, 1'b0, 16'h0, 2'b00);
        run_beat("lane_iso", 1'b1, 2'b01, 2'b00, 16'h0500, 16'h0500, 2'b00, 1'b0, 16'h0, 2'b00);
        run_beat("dual_neg", 1'b1, 2'b11, 2'b00, 16'h0101, 16'hFFFF, 2'b00, 1'b0, 16'h0, 2'b00);
        run_beat("lo_pos_ovf", 1'b1, 2'b00, 2'b00, 16'h0090, 16'h007F, 2'b01, 1'b1, 16'h0090, 2'b01);

        // T5 backpressure
        @(negedge clk);
        if_s.out_ready = 1'b0;
        drive(1'b1, 1'b0, 2'b00, 2'b00, 16'h0011);
        #1 chk("T5_rdy0", 32'(if_s.in_ready), 32'd1);
        @(negedge clk);
        chk("T5_valid_lo", 32'(if_s.out_valid), 32'd0);
        drive(1'b1, 1'b0, 2'b00, 2'b00, 16'h0022);
        #1 chk("T5_rdy1", 32'(if_s.in_ready), 32'd1);
        @(negedge clk);
        drive(1'b1, 1'b0, 2'b00, 2'b00, 16'h0033);
        #1 chk("T5_full", 32'(if_s.in_ready), 32'd0);
        chk("T5_valid_b0", 32'(if_s.out_valid), 32'd1);
        chk("T5_res_b0", 32'(if_s.res), 32'h0011);
        @(negedge clk);
        chk("T5_still_full", 32'(if_s.in_ready), 32'd0);
        chk("T5_stable_b0", 32'(if_s.res), 32'h0011);
        if_s.out_ready = 1'b1;
        #1 chk("T5_rdy_comb", 32'(if_s.in_ready), 32'd1);
        @(negedge clk);
        chk("T5_valid_b1", 32'(if_s.out_valid), 32'd1);
        chk("T5_res_b1", 32'(if_s.res), 32'h0022);
        drive(1'b1, 1'b0, 2'b00, 2'b00, 16'h0044);
        #1 chk("T5_rdy3", 32'(if_s.in_ready), 32'd1);
        @(negedge clk);
        drive(1'b0, 1'b0, 2'b00, 2'b00, 16'h0000);
        chk("T5_res_b2", 32'(if_s.res), 32'h0033);
        @(negedge clk);
        chk("T5_valid_b3", 32'(if_s.out_valid), 32'd1);
        chk("T5_res_b3", 32'(if_s.res), 32'h0044);
        @(negedge clk);
        chk("T5_drained", 32'(if_s.out_valid), 32'd0);

        // T6 reset with two beats in flight
        @(negedge clk);
        drive(1'b1, 1'b0, 2'b00, 2'b00, 16'h0101);
        @(negedge clk);
        drive(1'b1, 1'b0, 2'b00, 2'b00, 16'h0202);
        @(negedge clk);
        drive(1'b0, 1'b0, 2'b00, 2'b00, 16'h0000);
        chk("T6_inflight", 32'(if_s.out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("T6_async_valid", 32'(if_s.out_valid), 32'd0);
        chk("T6_async_res", 32'(if_s.res), 32'd0);
        chk("T6_async_ovf", 32'(if_s.ovf), 32'd0);
        chk("T6_async_rdy", 32'(if_s.in_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("T6_no_stale0", 32'(if_s.out_valid), 32'd0);
        @(negedge clk);
        chk("T6_no_stale1", 32'(if_s.out_valid), 32'd0);
        run_beat("T6_new", 1'b0, 2'b01, 2'b00, 16'h0002, 16'hFFFE, 2'b00, 1'b1, 16'hFFFE, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
